// File: rtl/exp_1x1_pkg.sv
// Shared definitions for the expand 1x1 kernel-RAM read path.
package exp_1x1_pkg;

  localparam int unsigned EXP1_ADDR_W = 12;
  localparam int unsigned EXP1_DATA_W = 64;

  // Read-engine FSM: idle waiting for a window, or walking the window.
  typedef enum logic [0:0] {
    StWaitAddr = 1'b0,
    StRead     = 1'b1
  } exp1_state_e;

endpackage

// File: rtl/exp_1x1_ker_fifo.sv
// Synchronous first-word-fall-through FIFO for returned kernel words.
// Head entry is visible on rdata_o whenever count_o is non-zero.
module exp_1x1_ker_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop_eff;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // An empty FIFO never pops, whatever the consumer asks for.
  always_comb begin
    pop_eff = pop_i && (count_q != '0);
  end

  // Pointer and occupancy tracking with synchronous flush.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_eff) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_eff})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/exp_1x1_ker_ram_rd.sv
// Expand 1x1 kernel-RAM read engine: walks an inclusive address window,
// buffers returned words under credit control, and streams them out.
module exp_1x1_ker_ram_rd
  import exp_1x1_pkg::*;
#(
  parameter int unsigned ADDR_W     = EXP1_ADDR_W,
  parameter int unsigned DATA_W     = EXP1_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] rd_addr_layr_start_i,
  input  logic              rd_start_addr_flag_i,
  input  logic [ADDR_W-1:0] rd_addr_layr_end_i,
  input  logic              rd_end_addr_flag_i,
  output logic              exp_1x1_kerl_req_o,
  output logic              chk_nxt_fire_addr_limt_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic [DATA_W-1:0] ker_data_o,
  output logic              ker_valid_o,
  input  logic              ker_ready_i,
  output logic              ker_last_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  exp1_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] start_q, end_q;
  logic              inflight_q, tag_q;

  logic              flush, req, start_cap, end_cap;
  logic              issue, last_issue, credit_ok;
  logic [CntW:0]     credit_sum;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_valid, fifo_pop;

  // Issue control, flag capture and FSM next state.
  always_comb begin
    flush      = rst_i || start_i;
    credit_sum = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    credit_ok  = credit_sum < DepthC;
    issue      = !flush && (state_q == StRead) && credit_ok;
    last_issue = issue && (cur_addr_q == end_q);
    // The strobe rises on the last issue so the next window can launch back-to-back.
    req        = !flush && ((state_q == StWaitAddr) || last_issue);
    start_cap  = rd_start_addr_flag_i && req;
    end_cap    = rd_end_addr_flag_i && req;

    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    if (issue) cur_addr_d = cur_addr_q + ADDR_W'(1);
    if (last_issue) state_d = StWaitAddr;
    if (end_cap) begin
      state_d    = StRead;
      cur_addr_d = start_cap ? rd_addr_layr_start_i : start_q;
    end
  end

  // State, window registers and the one-deep in-flight tag pipeline.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q    <= StWaitAddr;
      cur_addr_q <= '0;
      start_q    <= '0;
      end_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      if (start_cap) start_q <= rd_addr_layr_start_i;
      if (end_cap)   end_q   <= rd_addr_layr_end_i;
      inflight_q <= issue;
      tag_q      <= last_issue;
    end
  end

  exp_1x1_ker_fifo #(
    .Width (DATA_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .flush_i (flush),
    .push_i  (inflight_q),
    .wdata_i ({tag_q, ram_rd_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  // Output stream; everything is forced low while flushing.
  always_comb begin
    fifo_valid               = fifo_count != '0;
    ker_valid_o              = fifo_valid && !flush;
    fifo_pop                 = ker_valid_o && ker_ready_i;
    ker_data_o               = ker_valid_o ? fifo_rdata[DATA_W-1:0] : '0;
    ker_last_o               = ker_valid_o && fifo_rdata[DATA_W];
    ram_rd_en_o              = issue;
    ram_rd_addr_o            = issue ? cur_addr_q : '0;
    chk_nxt_fire_addr_limt_o = last_issue;
    exp_1x1_kerl_req_o       = req;
  end

endmodule
